// File: rtl/led_ctrl.sv
// led_ctrl: multi-channel OFF/ON/BLINK/CODE LED controller on a shared tick; define LED_ACTIVE_LOW_EN for inverted O_led
module led_ctrl #(
  parameter int         CH_NUM     = 4,
  parameter int         CLK_DIV    = 25000,
  parameter int         PER_W      = 16,
  parameter int         CNT_W      = 4,
  parameter int         GAP_TICKS  = 1000,
  parameter logic [1:0] RST_MODE   = 2'd2,
  parameter int         RST_PERIOD = 600
) (
  input  logic              I_clk,
  input  logic              I_reset_n,
  input  logic              I_wr_en,
  input  logic [3:0]        I_wr_ch,
  input  logic [1:0]        I_wr_mode,
  input  logic [PER_W-1:0]  I_wr_period,
  input  logic [CNT_W-1:0]  I_wr_count,
  output logic [CH_NUM-1:0] O_led,
  output logic              O_tick
);
  localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = $clog2(GAP_TICKS + 1);
  localparam int PH_W  = PER_W > GAP_W ? PER_W : GAP_W;
`ifdef LED_ACTIVE_LOW_EN
  localparam logic LED_INV = 1'b1;
`else
  localparam logic LED_INV = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, ON_PH, OFF_PH, GAP} state_t;
  logic [DIV_W-1:0] r_div;
  logic             w_wr_ok;
  logic             w_run;
  logic [PER_W-1:0] w_per;
  assign O_tick  = r_div == DIV_W'(CLK_DIV - 1);
  assign w_wr_ok = I_wr_en && ({1'b0, I_wr_ch} < 5'(CH_NUM));
  assign w_run   = I_wr_mode == 2'd2 || (I_wr_mode == 2'd3 && I_wr_count != '0);
  assign w_per   = I_wr_period == '0 ? PER_W'(1) : I_wr_period;
  always_ff @(posedge I_clk or negedge I_reset_n)
    if (!I_reset_n) r_div <= '0;
    else r_div <= O_tick ? '0 : r_div + 1'b1;
  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    logic [1:0]       r_mode;
    logic [PER_W-1:0] r_per;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_flash;
    logic [PH_W-1:0]  r_ph;
    state_t           r_st;
    logic             r_led;
    logic             w_wr;
    logic             w_end;
    logic             w_lit;
    assign w_wr  = w_wr_ok && I_wr_ch == 4'(c);
    assign w_end = r_ph == (r_st == GAP ? PH_W'(GAP_TICKS - 1) : PH_W'(r_per) - 1'b1);
    assign w_lit = r_st == ON_PH || (r_st == IDLE && r_mode == 2'd1);
    assign O_led[c] = r_led;
    // a write takes precedence over a coincident tick; r_led tracks the state being entered
    always_ff @(posedge I_clk or negedge I_reset_n)
      if (!I_reset_n) begin
        r_mode  <= RST_MODE;
        r_per   <= PER_W'(RST_PERIOD);
        r_cnt   <= '0;
        r_flash <= '0;
        r_ph    <= '0;
        r_st    <= ON_PH;
        r_led   <= LED_INV;
      end else if (w_wr) begin
        r_mode  <= I_wr_mode;
        r_per   <= w_per;
        r_cnt   <= I_wr_count;
        r_flash <= '0;
        r_ph    <= '0;
        r_st    <= w_run ? ON_PH : IDLE;
        r_led   <= LED_INV ^ (w_run || I_wr_mode == 2'd1);
      end else begin
        r_led <= LED_INV ^ w_lit;
        if (O_tick && r_st != IDLE) begin
          r_ph <= w_end ? '0 : r_ph + 1'b1;
          if (w_end)
            case (r_st)
              ON_PH: begin
                r_st  <= OFF_PH;
                r_led <= LED_INV;
              end
              OFF_PH:
                if (r_mode == 2'd3 && r_flash + 1'b1 == r_cnt) begin
                  r_flash <= '0;
                  r_st    <= GAP;
                end else begin
                  r_flash <= r_mode == 2'd3 ? r_flash + 1'b1 : r_flash;
                  r_st    <= ON_PH;
                  r_led   <= ~LED_INV;
                end
              default: begin
                r_st  <= ON_PH;
                r_led <= ~LED_INV;
              end
            endcase
        end
      end
  end
endmodule

// File: tb/tb_led_ctrl.sv
// tb_led_ctrl: scoreboard bench for led_ctrl; expected LEDs come from a tick-count waveform model
module tb_led_ctrl;
  localparam int CH = 4;
  localparam int DIV = 4;
  localparam int GAPT = 3;
`ifdef LED_ACTIVE_LOW_EN
  localparam logic [CH-1:0] INV = '1;
`else
  localparam logic [CH-1:0] INV = '0;
`endif
  logic          I_clk = 1'b0;
  logic          I_reset_n = 1'b0;
  logic          I_wr_en = 1'b0;
  logic [3:0]    I_wr_ch = '0;
  logic [1:0]    I_wr_mode = '0;
  logic [15:0]   I_wr_period = '0;
  logic [3:0]    I_wr_count = '0;
  logic [CH-1:0] O_led;
  logic          O_tick;
  int checks = 0;
  int failures = 0;
  string phase = "reset";
  logic [CH:0] exp_q[$];
  int m_mode[CH];
  int m_per[CH];
  int m_cnt[CH];
  int m_t[CH];
  int m_div;

  led_ctrl #(
    .CH_NUM(CH), .CLK_DIV(DIV), .PER_W(16), .CNT_W(4),
    .GAP_TICKS(GAPT), .RST_MODE(2'd2), .RST_PERIOD(2)
  ) dut (
    .I_clk(I_clk), .I_reset_n(I_reset_n), .I_wr_en(I_wr_en), .I_wr_ch(I_wr_ch),
    .I_wr_mode(I_wr_mode), .I_wr_period(I_wr_period), .I_wr_count(I_wr_count),
    .O_led(O_led), .O_tick(O_tick)
  );

  always #5 I_clk = ~I_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic lit(input int c);
    int p = m_per[c];
    int n = m_cnt[c];
    int pos;
    if (m_mode[c] == 1) return 1'b1;
    if (m_mode[c] == 0 || (m_mode[c] == 3 && n == 0)) return 1'b0;
    if (m_mode[c] == 2) return ((m_t[c] / p) % 2) == 0;
    pos = m_t[c] % (2 * p * n + GAPT);
    return pos < 2 * p * n && ((pos / p) % 2) == 0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_mode[c] = 2;
      m_per[c]  = 2;
      m_cnt[c]  = 0;
      m_t[c]    = 0;
    end
    m_div = 0;
    exp_q.delete();
  endtask

  task automatic step(input int we, input int ch, input int md, input int per, input int cnt);
    logic          tick;
    logic [CH-1:0] e;
    logic [CH:0]   x;
    I_wr_en     = we[0];
    I_wr_ch     = 4'(ch);
    I_wr_mode   = 2'(md);
    I_wr_period = 16'(per);
    I_wr_count  = 4'(cnt);
    tick = m_div == DIV - 1;
    for (int c = 0; c < CH; c++)
      if (we != 0 && ch == c) begin
        m_mode[c] = md;
        m_per[c]  = per == 0 ? 1 : per;
        m_cnt[c]  = cnt;
        m_t[c]    = 0;
      end else if (tick) m_t[c]++;
    m_div = (m_div + 1) % DIV;
    for (int c = 0; c < CH; c++) e[c] = lit(c);
    exp_q.push_back({m_div == DIV - 1, e ^ INV});
    @(posedge I_clk);
    #1;
    I_wr_en = 1'b0;
    x = exp_q.pop_front();
    check({phase, " led"}, 32'(O_led), 32'(x[CH-1:0]));
    check({phase, " tick"}, 32'(O_tick), 32'(x[CH]));
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  task automatic reset_checks();
    check("reset led", 32'(O_led), 32'(INV));
    check("reset tick", 32'(O_tick), 32'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge I_clk);
    #1;
    reset_checks();
    I_reset_n = 1'b1;
    phase = "blink";
    idle(40);
    phase = "on_off";
    step(1, 1, 1, 5, 0);
    step(1, 2, 0, 5, 0);
    idle(24);
    phase = "code";
    step(1, 3, 3, 1, 3);
    idle(60);
    phase = "clamp";
    step(1, 0, 2, 0, 0);
    idle(12);
    phase = "bad_ch";
    step(1, 5, 1, 7, 1);
    idle(12);
    phase = "wr_tick";
    while (m_div != DIV - 1) step(0, 0, 0, 0, 0);
    step(1, 2, 2, 2, 0);
    idle(20);
    phase = "code_cnt0";
    step(1, 2, 3, 3, 0);
    idle(8);
    phase = "code_p2";
    step(1, 3, 3, 2, 2);
    idle(30);
    phase = "mid_reset";
    I_reset_n = 1'b0;
    #1;
    reset_checks();
    @(posedge I_clk);
    #1;
    reset_checks();
    I_reset_n = 1'b1;
    model_reset();
    idle(40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
